// File: rtl/msh_wr_in_fifo.sv
// msh_wr_in_fifo: credit-based write-request input FIFO feeding msh_wr_dp.
// Each entry holds {addr, data}. A push is taken when the FIFO is not full.
// A push that arrives while full is dropped and sets a sticky overflow flag.
// One credit is returned upstream on the cycle after each pop.
// Optional feature macro: MSH_WR_IN_PAR_EN adds an even-parity check on the write data.
module msh_wr_in_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int DW    = 64
) (
    input  logic                     mclk,
    input  logic                     mrst_n,
    input  logic                     i_wr_vld,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [DW-1:0]            i_wr_data,
`ifdef MSH_WR_IN_PAR_EN
    input  logic                     i_wr_par,
`endif
    output logic                     o_wr_crd_rtn,
    output logic                     o_dp_vld,
    output logic [AW-1:0]            o_dp_addr,
    output logic [DW-1:0]            o_dp_data,
    input  logic                     i_dp_rdy,
    output logic [$clog2(DEPTH+1)-1:0] o_occ,
    output logic                     o_ovfl_err
`ifdef MSH_WR_IN_PAR_EN
    ,
    output logic                     o_par_err
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic          full;
    logic          push;
    logic          pop;

    // The full check looks only at the current occupancy, so a same-cycle pop never makes room for a push.
    assign full = (occ == OW'(DEPTH));
    assign push = i_wr_vld & ~full;
    assign pop  = (occ != '0) & i_dp_rdy;

    // The head comes straight from registered storage. Gating it with valid keeps it zero when the FIFO is empty or in reset.
    assign o_dp_vld  = (occ != '0);
    assign o_dp_addr = o_dp_vld ? addr_mem[rd_ptr] : '0;
    assign o_dp_data = o_dp_vld ? data_mem[rd_ptr] : '0;
    assign o_occ     = occ;

    // Entry storage. It has no reset because the outputs are masked while the FIFO is empty.
    always_ff @(posedge mclk) begin
        if (push) begin
            addr_mem[wr_ptr] <= i_wr_addr;
            data_mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Credit return is the pop delayed by one cycle. Back-to-back pops give back-to-back pulses.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            o_wr_crd_rtn <= 1'b0;
        end else begin
            o_wr_crd_rtn <= pop;
        end
    end

    // Sticky overflow flag. It is set by any request that arrives while the FIFO is full.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            o_ovfl_err <= 1'b0;
        end else if (i_wr_vld && full) begin
            o_ovfl_err <= 1'b1;
        end
    end

`ifdef MSH_WR_IN_PAR_EN
    // Sticky parity-error flag. It checks even parity on accepted pushes only; the entry itself is stored unchanged.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            o_par_err <= 1'b0;
        end else if (push && ((^i_wr_data) != i_wr_par)) begin
            o_par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_msh_wr_in_fifo.sv
// tb_msh_wr_in_fifo: scoreboard bench for msh_wr_in_fifo (DEPTH=8, AW=16, DW=64).
// The stimulus side queues the expected entries. A negedge monitor pops the queue and compares on each handshake.
module tb_msh_wr_in_fifo;

    logic        mclk;
    logic        mrst_n;
    logic        i_wr_vld;
    logic [15:0] i_wr_addr;
    logic [63:0] i_wr_data;
    logic        o_wr_crd_rtn;
    logic        o_dp_vld;
    logic [15:0] o_dp_addr;
    logic [63:0] o_dp_data;
    logic        i_dp_rdy;
    logic [3:0]  o_occ;
    logic        o_ovfl_err;
`ifdef MSH_WR_IN_PAR_EN
    logic        i_wr_par;
    logic        o_par_err;
    logic        exp_par;
`endif

    int          vectors;
    int          miscompares;
    int          crd_count;
    int          exp_occ;
    logic        exp_ovfl;
    logic        exp_crd;
    logic [79:0] sb [$];

    msh_wr_in_fifo #(.DEPTH(8), .AW(16), .DW(64)) dut (
        .mclk         (mclk),
        .mrst_n       (mrst_n),
        .i_wr_vld     (i_wr_vld),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
`ifdef MSH_WR_IN_PAR_EN
        .i_wr_par     (i_wr_par),
`endif
        .o_wr_crd_rtn (o_wr_crd_rtn),
        .o_dp_vld     (o_dp_vld),
        .o_dp_addr    (o_dp_addr),
        .o_dp_data    (o_dp_data),
        .i_dp_rdy     (i_dp_rdy),
        .o_occ        (o_occ),
        .o_ovfl_err   (o_ovfl_err)
`ifdef MSH_WR_IN_PAR_EN
        ,
        .o_par_err    (o_par_err)
`endif
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on each handshake seen at negedge, pop the queue and compare the head entry.
    always @(negedge mclk) begin
        if (mrst_n && o_dp_vld && i_dp_rdy) begin
            if (sb.size() == 0) begin
                check_output("unexpected_entry", {48'h0, o_dp_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [79:0] e;
                e = sb.pop_front();
                check_output("head_addr", {48'h0, o_dp_addr}, {48'h0, e[79:64]});
                check_output("head_data", o_dp_data, e[63:0]);
            end
        end
    end

    // Drive one cycle of inputs, update the expected model, then check the registered outputs after the edge.
    task automatic apply_stimulus(input logic vld, input logic [15:0] addr, input logic [63:0] data,
                                  input logic rdy, input logic bad_par);
        logic pushed;
        logic popped;
        i_wr_vld  = vld;
        i_wr_addr = addr;
        i_wr_data = data;
        i_dp_rdy  = rdy;
`ifdef MSH_WR_IN_PAR_EN
        i_wr_par  = (^data) ^ bad_par;
`endif
        pushed = vld && (exp_occ < 8);
        popped = rdy && (exp_occ > 0);
        if (vld && exp_occ == 8) exp_ovfl = 1'b1;
        if (pushed) sb.push_back({addr, data});
`ifdef MSH_WR_IN_PAR_EN
        if (pushed && bad_par) exp_par = 1'b1;
`endif
        exp_occ = exp_occ + (pushed ? 1 : 0) - (popped ? 1 : 0);
        exp_crd = popped;
        @(posedge mclk);
        #1;
        if (o_wr_crd_rtn) crd_count++;
        check_output("occ", 64'(o_occ), 64'(exp_occ));
        check_output("dp_vld", 64'(o_dp_vld), 64'(exp_occ > 0));
        check_output("crd_rtn", 64'(o_wr_crd_rtn), 64'(exp_crd));
        check_output("ovfl_err", 64'(o_ovfl_err), 64'(exp_ovfl));
`ifdef MSH_WR_IN_PAR_EN
        check_output("par_err", 64'(o_par_err), 64'(exp_par));
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_occ"}, 64'(o_occ), 64'd0);
        check_output({tag, "_vld"}, 64'(o_dp_vld), 64'd0);
        check_output({tag, "_addr"}, 64'(o_dp_addr), 64'd0);
        check_output({tag, "_data"}, o_dp_data, 64'd0);
        check_output({tag, "_crd"}, 64'(o_wr_crd_rtn), 64'd0);
        check_output({tag, "_ovfl"}, 64'(o_ovfl_err), 64'd0);
`ifdef MSH_WR_IN_PAR_EN
        check_output({tag, "_par"}, 64'(o_par_err), 64'd0);
`endif
    endtask

    // Hold reset across two edges, check that every output is zero, then release just after an edge.
    task automatic do_reset();
        mrst_n    = 1'b0;
        i_wr_vld  = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_dp_rdy  = 1'b0;
`ifdef MSH_WR_IN_PAR_EN
        i_wr_par  = 1'b0;
        exp_par   = 1'b0;
`endif
        repeat (2) @(posedge mclk);
        #1;
        check_zero_outputs("reset");
        sb.delete();
        exp_occ  = 0;
        exp_ovfl = 1'b0;
        exp_crd  = 1'b0;
        mrst_n   = 1'b1;
    endtask

    // Directed test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        crd_count   = 0;
        exp_occ     = 0;
        exp_ovfl    = 1'b0;
        exp_crd     = 1'b0;
        do_reset();

        // Push-to-valid latency, then the pop and the credit pulse that follows it.
        apply_stimulus(1'b1, 16'h10, 64'h1, 1'b1, 1'b0);
        check_output("lat_vld", 64'(o_dp_vld), 64'd1);
        check_output("lat_addr", 64'(o_dp_addr), 64'h10);
        apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);
        check_output("lat_crd", 64'(o_wr_crd_rtn), 64'd1);
        check_output("lat_occ", 64'(o_occ), 64'd0);
        apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);
        check_output("lat_crd_end", 64'(o_wr_crd_rtn), 64'd0);

        // Fill with nine pushes; the ninth must be dropped. Then drain and count the credits.
        for (int i = 0; i < 9; i++)
            apply_stimulus(1'b1, 16'h20 + 16'(i), 64'h100 + 64'(i), 1'b0, 1'b0);
        check_output("fill_occ", 64'(o_occ), 64'd8);
        check_output("fill_ovfl", 64'(o_ovfl_err), 64'd1);
        crd_count = 0;
        for (int i = 0; i < 9; i++)
            apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);
        check_output("drain_credits", 64'(crd_count), 64'd8);
        check_output("drain_occ", 64'(o_occ), 64'd0);

        // Push and pop together while full: the push is dropped and occupancy falls to 7.
        do_reset();
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 16'h40 + 16'(i), 64'h200 + 64'(i), 1'b0, 1'b0);
        check_output("full_no_ovfl", 64'(o_ovfl_err), 64'd0);
        apply_stimulus(1'b1, 16'hEE, 64'hEE, 1'b1, 1'b0);
        check_output("simul_occ", 64'(o_occ), 64'd7);
        check_output("simul_ovfl", 64'(o_ovfl_err), 64'd1);
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);

        // Wrap-around: 20 pushes with concurrent pops, holding occupancy at 3.
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 16'h60 + 16'(i), 64'h300 + 64'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 16'h80 + 16'(i), 64'hA000 + 64'(i), 1'b1, 1'b0);
            check_output("wrap_occ", 64'(o_occ), 64'd3);
        end
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);

        // Reset in mid-operation with five entries stored, then one push after release.
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, 16'h90 + 16'(i), 64'h500 + 64'(i), 1'b0, 1'b0);
        i_wr_vld = 1'b0;
        mrst_n   = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        do_reset();
        apply_stimulus(1'b1, 16'h77, 64'h77, 1'b0, 1'b0);
        check_output("post_rst_occ", 64'(o_occ), 64'd1);
        for (int i = 0; i < 2; i++)
            apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);

`ifdef MSH_WR_IN_PAR_EN
        // Parity: D=0x1 with parity bit 0 is a mismatch. The entry is still delivered, and the flag is sticky.
        apply_stimulus(1'b1, 16'h33, 64'h1, 1'b0, 1'b1);
        check_output("par_set", 64'(o_par_err), 64'd1);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, 16'h0, 64'h0, 1'b1, 1'b0);
        check_output("par_sticky", 64'(o_par_err), 64'd1);
`endif

        check_output("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
